// File: rtl/tc141_skidbufx_pkg.sv
// Shared constants for the tc141_skidbufx two-entry skid buffer.
package tc141_skidbufx_pkg;

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_FULL  = 2'd2;

  localparam int unsigned CNTW_DEFAULT = 16;

endpackage

// File: rtl/tc141_skidbufx_ctl.sv
// Occupancy state machine for tc141_skidbufx; emits handshake outputs and datapath load strobes.
module tc141_skidbufx_ctl
  import tc141_skidbufx_pkg::*;
(
  input  logic clk,
  input  logic rst_,
  input  logic ivld,
  input  logic ordy,
  output logic ovld,
  output logic irdy,
  output logic main_load,
  output logic main_sel_skid,
  output logic skid_load
);

  logic [1:0] state_q, state_d;

  always_ff @(posedge clk or posedge rst_) begin
    if (rst_) state_q <= ST_EMPTY;
    else      state_q <= state_d;
  end

  assign ovld = (state_q != ST_EMPTY);
  assign irdy = (state_q != ST_FULL) && !rst_;

  always_comb begin
    state_d       = state_q;
    main_load     = 1'b0;
    main_sel_skid = 1'b0;
    skid_load     = 1'b0;
    case (state_q)
      ST_EMPTY: begin
        if (ivld) begin
          main_load = 1'b1;
          state_d   = ST_ONE;
        end
      end
      ST_ONE: begin
        if (ivld && ordy) begin
          main_load = 1'b1;
        end else if (ivld) begin
          skid_load = 1'b1;
          state_d   = ST_FULL;
        end else if (ordy) begin
          state_d = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (ordy) begin
          main_load     = 1'b1;
          main_sel_skid = 1'b1;
          state_d       = ST_ONE;
        end
      end
      // Encoding 2'd3 is unreachable; fall back to empty.
      default: state_d = ST_EMPTY;
    endcase
  end

endmodule

// File: rtl/tc141_skidbufx.sv
// Two-entry elastic register slice with registered valid/ready/data on both sides.
// Optional stall counter port ostall_cnt enabled by TC141_SKIDBUFX_STALLCNT_EN.
module tc141_skidbufx
  import tc141_skidbufx_pkg::*;
#(
  parameter int unsigned      WIDTH       = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{1'b0}},
  parameter int unsigned      CNTW        = CNTW_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_,
  input  logic             ivld,
  output logic             irdy,
  input  logic [WIDTH-1:0] idat,
  output logic             ovld,
  input  logic             ordy,
  output logic [WIDTH-1:0] odat
`ifdef TC141_SKIDBUFX_STALLCNT_EN
  ,
  output logic [CNTW-1:0]  ostall_cnt
`endif
);

  logic             main_load, main_sel_skid, skid_load;
  logic [WIDTH-1:0] main_q, main_d;
  logic [WIDTH-1:0] skid_q, skid_d;

  tc141_skidbufx_ctl u_ctl (
    .clk          (clk),
    .rst_         (rst_),
    .ivld         (ivld),
    .ordy         (ordy),
    .ovld         (ovld),
    .irdy         (irdy),
    .main_load    (main_load),
    .main_sel_skid(main_sel_skid),
    .skid_load    (skid_load)
  );

  always_comb begin
    main_d = main_q;
    skid_d = skid_q;
    if (main_load) main_d = main_sel_skid ? skid_q : idat;
    if (skid_load) skid_d = idat;
  end

  always_ff @(posedge clk or posedge rst_) begin
    if (rst_) begin
      main_q <= RESET_VALUE;
      skid_q <= RESET_VALUE;
    end else begin
      main_q <= main_d;
      skid_q <= skid_d;
    end
  end

  assign odat = main_q;

`ifdef TC141_SKIDBUFX_STALLCNT_EN
  logic [CNTW-1:0] stall_cnt_q, stall_cnt_d;

  // Saturating: stops at all-ones rather than wrapping.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (ovld && !ordy && !(&stall_cnt_q)) stall_cnt_d = stall_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst_) begin
    if (rst_) stall_cnt_q <= '0;
    else      stall_cnt_q <= stall_cnt_d;
  end

  assign ostall_cnt = stall_cnt_q;
`else
  logic [CNTW-1:0] unused_stall_cnt;
  assign unused_stall_cnt = '0;
`endif

endmodule

// File: tb/tb_tc141_skidbufx.sv
// Self-checking bench for tc141_skidbufx: directed vector table, hand sequences, random scoreboard.
module tb_tc141_skidbufx;

  localparam int unsigned      WIDTH = 8;
  localparam logic [WIDTH-1:0] RV    = 8'hFF;

  logic             clk, rst_;
  logic             ivld, irdy, ovld, ordy;
  logic [WIDTH-1:0] idat, odat;
`ifdef TC141_SKIDBUFX_STALLCNT_EN
  logic [15:0] stall_cnt;
  logic [3:0]  stall_cnt4;
  logic        irdy4, ovld4;
  logic [7:0]  odat4;
`endif

  tc141_skidbufx #(.WIDTH(WIDTH), .RESET_VALUE(RV)) dut (
    .clk (clk),
    .rst_(rst_),
    .ivld(ivld),
    .irdy(irdy),
    .idat(idat),
    .ovld(ovld),
    .ordy(ordy),
    .odat(odat)
`ifdef TC141_SKIDBUFX_STALLCNT_EN
    ,
    .ostall_cnt(stall_cnt)
`endif
  );

`ifdef TC141_SKIDBUFX_STALLCNT_EN
  tc141_skidbufx #(.WIDTH(WIDTH), .RESET_VALUE(RV), .CNTW(4)) dut4 (
    .clk       (clk),
    .rst_      (rst_),
    .ivld      (ivld),
    .irdy      (irdy4),
    .idat      (idat),
    .ovld      (ovld4),
    .ordy      (ordy),
    .odat      (odat4),
    .ostall_cnt(stall_cnt4)
  );
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: FIFO of accepted beats plus the last value left in the output register.
  logic [WIDTH-1:0] q[$];
  logic [WIDTH-1:0] last;

  task automatic check_model(input string tag);
    check({tag, ".ovld"}, {31'd0, ovld}, {31'd0, q.size() > 0});
    check({tag, ".irdy"}, {31'd0, irdy}, {31'd0, q.size() < 2});
    check({tag, ".odat"}, {24'd0, odat}, {24'd0, (q.size() > 0) ? q[0] : last});
  endtask

  // Applies one cycle of inputs (caller is 1 time unit after a posedge) and advances the model.
  task automatic cyc(input logic v, input logic [WIDTH-1:0] d, input logic r);
    logic in_x, out_x;
    ivld  = v;
    idat  = d;
    ordy  = r;
    in_x  = v && (q.size() < 2);
    out_x = r && (q.size() > 0);
    @(posedge clk);
    #1;
    if (out_x) last = q.pop_front();
    if (in_x) q.push_back(d);
  endtask

  typedef struct {
    logic             v;
    logic [WIDTH-1:0] d;
    logic             r;
    logic             e_ovld;
    logic             e_irdy;
    logic [WIDTH-1:0] e_odat;
  } vec_t;

  vec_t tbl[12];

  initial begin
    logic prev_hold;
    logic [WIDTH-1:0] prev_odat;
    int guard;

    // Stall A1/A2/A3, release in order, then a lone 0x3C draining to empty.
    tbl[0]  = '{1'b1, 8'hA1, 1'b0, 1'b0, 1'b1, 8'hFF};
    tbl[1]  = '{1'b1, 8'hA2, 1'b0, 1'b1, 1'b1, 8'hA1};
    tbl[2]  = '{1'b1, 8'hA3, 1'b0, 1'b1, 1'b0, 8'hA1};
    tbl[3]  = '{1'b1, 8'hA3, 1'b0, 1'b1, 1'b0, 8'hA1};
    tbl[4]  = '{1'b1, 8'hA3, 1'b1, 1'b1, 1'b0, 8'hA1};
    tbl[5]  = '{1'b1, 8'hA3, 1'b1, 1'b1, 1'b1, 8'hA2};
    tbl[6]  = '{1'b0, 8'hEE, 1'b1, 1'b1, 1'b1, 8'hA3};
    tbl[7]  = '{1'b0, 8'hEE, 1'b1, 1'b0, 1'b1, 8'hA3};
    tbl[8]  = '{1'b1, 8'h3C, 1'b1, 1'b0, 1'b1, 8'hA3};
    tbl[9]  = '{1'b0, 8'hEE, 1'b1, 1'b1, 1'b1, 8'h3C};
    tbl[10] = '{1'b0, 8'hEE, 1'b1, 1'b0, 1'b1, 8'h3C};
    tbl[11] = '{1'b0, 8'hEE, 1'b1, 1'b0, 1'b1, 8'h3C};

    ivld = 1'b0; ordy = 1'b0; idat = '0;
    rst_ = 1'b1;
    last = RV;
    #2;
    check("rst.ovld", {31'd0, ovld}, 32'd0);
    check("rst.irdy", {31'd0, irdy}, 32'd0);
    check("rst.odat", {24'd0, odat}, {24'd0, RV});
    @(negedge clk); @(negedge clk);
    rst_ = 1'b0;
    #1;
    check("rel.irdy", {31'd0, irdy}, 32'd1);
    @(posedge clk); #1;

    foreach (tbl[i]) begin
      check($sformatf("tbl%0d.ovld", i), {31'd0, ovld}, {31'd0, tbl[i].e_ovld});
      check($sformatf("tbl%0d.irdy", i), {31'd0, irdy}, {31'd0, tbl[i].e_irdy});
      check($sformatf("tbl%0d.odat", i), {24'd0, odat}, {24'd0, tbl[i].e_odat});
      cyc(tbl[i].v, tbl[i].d, tbl[i].r);
    end

    // Streaming: one beat per cycle, 1-cycle latency, irdy stays high.
    for (int i = 0; i < 17; i++) begin
      check($sformatf("str%0d.irdy", i), {31'd0, irdy}, 32'd1);
      if (i > 0) begin
        check($sformatf("str%0d.ovld", i), {31'd0, ovld}, 32'd1);
        check($sformatf("str%0d.odat", i), {24'd0, odat}, i);
      end
      cyc(i < 16, 8'(i + 1), 1'b1);
    end
    check("str.drained", {31'd0, ovld}, 32'd0);

`ifdef TC141_SKIDBUFX_STALLCNT_EN
    // One beat held with ordy low: counters see exactly the stalled cycles.
    cyc(1'b1, 8'h77, 1'b0);
    for (int i = 0; i < 20; i++) cyc(1'b0, 8'h00, 1'b0);
    check("cnt16.20", {16'd0, stall_cnt}, 32'd20);
    check("cnt4.sat20", {28'd0, stall_cnt4}, 32'd15);
    for (int i = 0; i < 20; i++) cyc(1'b0, 8'h00, 1'b0);
    check("cnt16.40", {16'd0, stall_cnt}, 32'd40);
    check("cnt4.sat40", {28'd0, stall_cnt4}, 32'd15);
    cyc(1'b0, 8'h00, 1'b1);
    check("cnt16.hold", {16'd0, stall_cnt}, 32'd40);
`endif

    // Fill to FULL with 0x55/0x66, then assert reset mid-cycle.
    cyc(1'b1, 8'h55, 1'b0);
    cyc(1'b1, 8'h66, 1'b0);
    check_model("full");
    check("full.irdy0", {31'd0, irdy}, 32'd0);
    ivld = 1'b0;
    rst_ = 1'b1;
    #1;
    check("rstf.ovld", {31'd0, ovld}, 32'd0);
    check("rstf.odat", {24'd0, odat}, {24'd0, RV});
    check("rstf.irdy", {31'd0, irdy}, 32'd0);
`ifdef TC141_SKIDBUFX_STALLCNT_EN
    check("rstf.cnt", {16'd0, stall_cnt}, 32'd0);
`endif
    @(negedge clk);
    rst_ = 1'b0;
    q.delete();
    last = RV;
    @(posedge clk); #1;
    check("rstf.irdy1", {31'd0, irdy}, 32'd1);
    check("rstf.ovld0", {31'd0, ovld}, 32'd0);

    // Random traffic: ivld ~50%, ordy ~30%, exact order via the model queue.
    prev_hold = 1'b0;
    prev_odat = '0;
    guard = 0;
    for (int i = 0; i < 3000; i++) begin
      check_model("rnd");
      if (prev_hold) check("rnd.stable", {24'd0, odat}, {24'd0, prev_odat});
      prev_hold = ovld && 1'b0;
      ordy = ($urandom_range(0, 9) < 3);
      prev_hold = ovld && !ordy;
      prev_odat = odat;
      cyc($urandom_range(0, 1) == 1, 8'($urandom), ordy);
    end

    // Drain remaining beats within a bounded number of cycles.
    while (q.size() > 0 && guard < 10) begin
      check_model("drn");
      cyc(1'b0, 8'h00, 1'b1);
      guard++;
    end
    check("drn.empty", {31'd0, ovld}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
